timer_irq: RTL and testbench

- Memory-mapped countdown timer. It is the interrupt source that drives one bit of the processor's HWInt vector, which feeds the coprocessor-0 interrupt logic.
- The CPU programs it with `sw` and reads it with `lw` through the bridge, using the word offsets below.
- On expiry it raises `IRQ`. In one-shot mode `IRQ` holds until software services it. In auto-reload mode it is a 1-cycle pulse.

---
 rtl/timer_irq_pkg.sv | 27 ++
 rtl/timer_irq_if.sv | 20 ++
 rtl/timer_irq.sv | 92 +++++++++
 tb/tb_timer_irq.sv | 221 ++++++++++++++++++++++
 4 files changed

// File: rtl/timer_irq_pkg.sv
// rtl/timer_irq_pkg.sv - register offsets, mode codes and FSM states for the countdown timer
package timer_irq_pkg;

  // Word offsets seen on Addr
  localparam logic [1:0] TIMER_CTRL   = 2'd0;
  localparam logic [1:0] TIMER_PRESET = 2'd1;
  localparam logic [1:0] TIMER_COUNT  = 2'd2;

  // MODE field values; codes 2 and 3 fall back to one-shot behaviour
  localparam logic [1:0] TIMER_MODE_ONCE   = 2'd0;
  localparam logic [1:0] TIMER_MODE_RELOAD = 2'd1;

  typedef enum logic [1:0] {
    TIMER_IDLE = 2'd0,
    TIMER_LOAD = 2'd1,
    TIMER_CNT  = 2'd2,
    TIMER_INT  = 2'd3
  } state_t;

  // Only these bits of a CTRL write are stored
  typedef struct packed {
    logic       im;
    logic [1:0] mode;
    logic       en;
  } ctrl_t;

endpackage

// File: rtl/timer_irq_if.sv
// rtl/timer_irq_if.sv - bridge-side register bus plus interrupt line of the timer
interface timer_irq_if #(
  parameter int WIDTH = 32
);
  logic [1:0]       Addr;
  logic             WE;
  logic [WIDTH-1:0] Din;
  logic [WIDTH-1:0] Dout;
  logic             IRQ;

  modport master (
    output Addr, WE, Din,
    input  Dout, IRQ
  );

  modport slave (
    input  Addr, WE, Din,
    output Dout, IRQ
  );
endinterface

// File: rtl/timer_irq.sv
// rtl/timer_irq.sv - memory-mapped countdown timer driving one HWInt interrupt bit
module timer_irq
  import timer_irq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic        Clk,
  input logic        Reset,
  timer_irq_if.slave bus
);

  ctrl_t            ctrl;
  logic [WIDTH-1:0] preset;
  logic [WIDTH-1:0] count;
  state_t           state;
  logic             irq_flag;

  logic reg_write;
  logic reload_mode;

  // Only CTRL and PRESET writes matter; COUNT and the unused slot ignore WE
  assign reg_write   = bus.WE && ((bus.Addr == TIMER_CTRL) || (bus.Addr == TIMER_PRESET));
  assign reload_mode = (ctrl.mode == TIMER_MODE_RELOAD);

  // Register file and countdown FSM; a software write overrides the FSM on that edge
  always_ff @(posedge Clk or negedge Reset) begin
    if (!Reset) begin
      ctrl     <= '0;
      preset   <= '0;
      count    <= '0;
      state    <= TIMER_IDLE;
      irq_flag <= 1'b0;
    end else if (reg_write) begin
      if (bus.Addr == TIMER_CTRL) begin
        ctrl <= ctrl_t'(bus.Din[3:0]);
      end else begin
        preset <= bus.Din;
      end
      state    <= TIMER_IDLE;
      irq_flag <= 1'b0;
    end else begin
      case (state)
        TIMER_IDLE: begin
          if (ctrl.en) begin
            state <= TIMER_LOAD;
          end
        end
        TIMER_LOAD: begin
          count <= preset;
          state <= TIMER_CNT;
        end
        TIMER_CNT: begin
          if (!ctrl.en) begin
            state <= TIMER_IDLE;
          end else if (count > WIDTH'(1)) begin
            count <= count - WIDTH'(1);
          end else begin
            // PRESET of 0 lands here straight away, so it behaves like 1
            count <= '0;
            state <= TIMER_INT;
          end
        end
        TIMER_INT: begin
          if (reload_mode) begin
            state <= TIMER_LOAD;
          end else begin
            ctrl.en  <= 1'b0;
            irq_flag <= 1'b1;
            state    <= TIMER_IDLE;
          end
        end
        default: state <= TIMER_IDLE;
      endcase
    end
  end

  // Read mux; CTRL upper bits are not stored and read back as zero
  always_comb begin
    bus.Dout = '0;
    case (bus.Addr)
      TIMER_CTRL:   bus.Dout = {{(WIDTH-4){1'b0}}, ctrl};
      TIMER_PRESET: bus.Dout = preset;
      TIMER_COUNT:  bus.Dout = count;
      default:      bus.Dout = '0;
    endcase
  end

  // Reload mode gives a single-cycle pulse; one-shot holds via irq_flag until serviced
  assign bus.IRQ = ctrl.im & (reload_mode ? (state == TIMER_INT)
                                          : (irq_flag | (state == TIMER_INT)));

endmodule

// File: tb/tb_timer_irq.sv
// tb/tb_timer_irq.sv - scoreboard bench for the countdown timer
module tb_timer_irq;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;

  always #5 Clk = ~Clk;

  timer_irq_if #(.WIDTH(32)) bus ();

  timer_irq #(.WIDTH(32)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  typedef struct {
    string       name;
    logic [31:0] dout;
    logic        irq;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   errors = 0;

  // Bus write: drive away from the edge, let one edge take it, release
  task automatic wr(input logic [1:0] a, input logic [31:0] d);
    bus.Addr = a;
    bus.Din  = d;
    bus.WE   = 1'b1;
    @(posedge Clk);
    #1;
    bus.WE   = 1'b0;
  endtask

  // Present a read address for one cycle and queue the expected response
  task automatic rd(input string n, input logic [1:0] a, input logic [31:0] d, input logic i);
    exp_t e;
    bus.Addr = a;
    e.name   = n;
    e.dout   = d;
    e.irq    = i;
    sb.push_back(e);
    @(posedge Clk);
    #1;
  endtask

  // Monitor: on each falling edge consume one queued expectation
  always @(negedge Clk) begin
    exp_t e;
    if (sb.size() > 0) begin
      e = sb.pop_front();
      checks++;
      if (bus.Dout !== e.dout) begin
        errors++;
        $display("FAIL %s dout: got %h want %h", e.name, bus.Dout, e.dout);
      end
      checks++;
      if (bus.IRQ !== e.irq) begin
        errors++;
        $display("FAIL %s irq: got %b want %b", e.name, bus.IRQ, e.irq);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bus.Addr = 2'd0;
    bus.WE   = 1'b0;
    bus.Din  = '0;
    @(posedge Clk);
    #1;

    // Reset state
    rd("rst_ctrl",   2'd0, 32'h0, 1'b0);
    rd("rst_preset", 2'd1, 32'h0, 1'b0);
    rd("rst_count",  2'd2, 32'h0, 1'b0);
    Reset = 1'b1;

    // Async reset mid-count, COUNT reaches 7 after edge 5
    wr(2'd1, 32'd10);
    wr(2'd0, 32'h1);
    rd("t1_e0", 2'd2, 32'd0,  1'b0);
    rd("t1_e1", 2'd2, 32'd0,  1'b0);
    rd("t1_e2", 2'd2, 32'd10, 1'b0);
    rd("t1_e3", 2'd2, 32'd9,  1'b0);
    rd("t1_e4", 2'd2, 32'd8,  1'b0);
    Reset    = 1'b0;
    bus.Addr = 2'd2;
    begin
      exp_t e;
      e.name = "t1_rst_count_now";
      e.dout = 32'd0;
      e.irq  = 1'b0;
      sb.push_back(e);
    end
    @(posedge Clk);
    #1;
    rd("t1_rst_ctrl",   2'd0, 32'h0, 1'b0);
    rd("t1_rst_preset", 2'd1, 32'h0, 1'b0);
    rd("t1_rst_addr3",  2'd3, 32'h0, 1'b0);
    Reset = 1'b1;

    // One-shot, PRESET 5: INT at edge 7, IRQ latched until CTRL write
    wr(2'd1, 32'd5);
    wr(2'd0, 32'h9);
    rd("t2_e0", 2'd2, 32'd0, 1'b0);
    rd("t2_e1", 2'd2, 32'd0, 1'b0);
    rd("t2_e2", 2'd2, 32'd5, 1'b0);
    rd("t2_e3", 2'd2, 32'd4, 1'b0);
    rd("t2_e4", 2'd2, 32'd3, 1'b0);
    rd("t2_e5", 2'd2, 32'd2, 1'b0);
    rd("t2_e6", 2'd2, 32'd1, 1'b0);
    rd("t2_e7", 2'd2, 32'd0, 1'b1);
    rd("t2_e8", 2'd0, 32'h8, 1'b1);
    rd("t2_e9", 2'd0, 32'h8, 1'b1);
    wr(2'd0, 32'h8);
    rd("t2_clr", 2'd0, 32'h8, 1'b0);

    // Auto-reload, PRESET 3: 1-cycle pulse every 5 cycles
    wr(2'd1, 32'd3);
    wr(2'd0, 32'hB);
    rd("t3_e0",  2'd2, 32'd0, 1'b0);
    rd("t3_e1",  2'd2, 32'd0, 1'b0);
    rd("t3_e2",  2'd2, 32'd3, 1'b0);
    rd("t3_e3",  2'd2, 32'd2, 1'b0);
    rd("t3_e4",  2'd2, 32'd1, 1'b0);
    rd("t3_e5",  2'd2, 32'd0, 1'b1);
    rd("t3_e6",  2'd2, 32'd0, 1'b0);
    rd("t3_e7",  2'd2, 32'd3, 1'b0);
    rd("t3_e8",  2'd2, 32'd2, 1'b0);
    rd("t3_e9",  2'd2, 32'd1, 1'b0);
    rd("t3_e10", 2'd2, 32'd0, 1'b1);
    rd("t3_e11", 2'd2, 32'd0, 1'b0);
    rd("t3_e12", 2'd0, 32'hB, 1'b0);
    wr(2'd0, 32'h0);

    // PRESET 0 behaves as 1: INT at edge 3
    wr(2'd1, 32'd0);
    wr(2'd0, 32'h9);
    rd("t4a_e0", 2'd1, 32'd0, 1'b0);
    rd("t4a_e1", 2'd1, 32'd0, 1'b0);
    rd("t4a_e2", 2'd1, 32'd0, 1'b0);
    rd("t4a_e3", 2'd2, 32'd0, 1'b1);
    rd("t4a_e4", 2'd0, 32'h8, 1'b1);

    // PRESET 1: INT at edge 3
    wr(2'd1, 32'd1);
    wr(2'd0, 32'h9);
    rd("t4b_e0", 2'd1, 32'd1, 1'b0);
    rd("t4b_e1", 2'd1, 32'd1, 1'b0);
    rd("t4b_e2", 2'd2, 32'd1, 1'b0);
    rd("t4b_e3", 2'd2, 32'd0, 1'b1);
    rd("t4b_e4", 2'd0, 32'h8, 1'b1);

    // MODE 2 falls back to one-shot
    wr(2'd1, 32'd1);
    wr(2'd0, 32'hD);
    rd("t4c_e0", 2'd0, 32'hD, 1'b0);
    rd("t4c_e1", 2'd0, 32'hD, 1'b0);
    rd("t4c_e2", 2'd0, 32'hD, 1'b0);
    rd("t4c_e3", 2'd2, 32'd0, 1'b1);
    rd("t4c_e4", 2'd0, 32'hC, 1'b1);

    // IM = 0 masks expiry; later CTRL write clears latched flag
    wr(2'd1, 32'd2);
    wr(2'd0, 32'h1);
    rd("t5_e0", 2'd0, 32'h1, 1'b0);
    rd("t5_e1", 2'd0, 32'h1, 1'b0);
    rd("t5_e2", 2'd2, 32'd2, 1'b0);
    rd("t5_e3", 2'd2, 32'd1, 1'b0);
    rd("t5_e4", 2'd2, 32'd0, 1'b0);
    rd("t5_e5", 2'd0, 32'h0, 1'b0);
    wr(2'd0, 32'h8);
    rd("t5_im_a", 2'd0, 32'h8, 1'b0);
    rd("t5_im_b", 2'd0, 32'h8, 1'b0);

    // PRESET write mid-count at COUNT 4 forces IDLE then reload
    wr(2'd1, 32'd6);
    wr(2'd0, 32'h1);
    rd("t6_e0", 2'd1, 32'd6, 1'b0);
    rd("t6_e1", 2'd1, 32'd6, 1'b0);
    rd("t6_e2", 2'd2, 32'd6, 1'b0);
    rd("t6_e3", 2'd2, 32'd5, 1'b0);
    wr(2'd1, 32'd10);
    rd("t6_idle", 2'd2, 32'd4,  1'b0);
    rd("t6_load", 2'd2, 32'd4,  1'b0);
    rd("t6_rl",   2'd2, 32'd10, 1'b0);
    rd("t6_dec",  2'd2, 32'd9,  1'b0);
    wr(2'd0, 32'h0);
    wr(2'd2, 32'h55);
    rd("t6_cnt_ro", 2'd2, 32'd8,  1'b0);
    rd("t6_addr3",  2'd3, 32'd0,  1'b0);
    rd("t6_preset", 2'd1, 32'd10, 1'b0);

    // Maximum PRESET counts down without wrap
    wr(2'd1, 32'hFFFF_FFFF);
    wr(2'd0, 32'h1);
    rd("t7_e0", 2'd1, 32'hFFFF_FFFF, 1'b0);
    rd("t7_e1", 2'd0, 32'h1,         1'b0);
    rd("t7_e2", 2'd2, 32'hFFFF_FFFF, 1'b0);
    rd("t7_e3", 2'd2, 32'hFFFF_FFFE, 1'b0);
    wr(2'd0, 32'h0);

    repeat (2) @(posedge Clk);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL sb_drain: got %0d pending want 0", sb.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
